// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and the GF(2^8) xtime helper for the
// MixColumns datapath.
package aes_pkg;

   localparam int unsigned NUM_COLS = 4;
   localparam int unsigned COL_W    = 32;
   localparam int unsigned BYTE_W   = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Multiply by x in GF(2^8), reduced by 0x11B.
   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
      return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1B : 8'h00);
   endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational forward MixColumns of one 32-bit column (s0 in the MSB byte).
module mix_single_column
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col_i,
   output logic [COL_W-1:0] col_o
);

   logic [BYTE_W-1:0] s0, s1, s2, s3;
   logic [BYTE_W-1:0] x0, x1, x2, x3;

   assign {s0, s1, s2, s3} = col_i;

   assign x0 = xtime(s0);
   assign x1 = xtime(s1);
   assign x2 = xtime(s2);
   assign x3 = xtime(s3);

   // 3*s is formed as xtime(s) ^ s.
   assign col_o = {x0 ^ (x1 ^ s1) ^ s2 ^ s3,
                   s0 ^ x1 ^ (x2 ^ s2) ^ s3,
                   s0 ^ s1 ^ x2 ^ (x3 ^ s3),
                   (x0 ^ s0) ^ s1 ^ s2 ^ x3};

endmodule

// File: rtl/mix_column_seq.sv
// Iterative forward MixColumns: one column per cycle through a shared mixer.
// Define MIXCOL_ARK_EN to fold the AddRoundKey XOR into each column write.
module mix_column_seq #(
   parameter int unsigned NUM_COLS = aes_pkg::NUM_COLS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_COLS*32-1:0]        block,
`ifdef MIXCOL_ARK_EN
   input  logic [NUM_COLS*32-1:0]        round_key,
`endif
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_COLS*32-1:0]        new_block
);

   import aes_pkg::*;

   localparam int unsigned BLOCK_W = NUM_COLS * COL_W;
   localparam int unsigned CNT_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NUM_COLS - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BLOCK_W-1:0]   work_q, work_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [COL_W-1:0]     col_in, col_mixed, col_new;

`ifdef MIXCOL_ARK_EN
   logic [BLOCK_W-1:0]   key_q, key_d;
   logic [COL_W-1:0]     key_col;
`endif

   // Column mux feeding the single shared mixer.
   always_comb begin
      col_in = '0;
`ifdef MIXCOL_ARK_EN
      key_col = '0;
`endif
      for (int unsigned c = 0; c < NUM_COLS; c++) begin
         if (cnt_q == CNT_W'(c)) begin
            col_in = work_q[BLOCK_W-1-COL_W*c -: COL_W];
`ifdef MIXCOL_ARK_EN
            key_col = key_q[BLOCK_W-1-COL_W*c -: COL_W];
`endif
         end
      end
   end

   mix_single_column u_mix (
      .col_i (col_in),
      .col_o (col_mixed)
   );

`ifdef MIXCOL_ARK_EN
   assign col_new = col_mixed ^ key_col;
`else
   assign col_new = col_mixed;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      work_d      = work_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
`ifdef MIXCOL_ARK_EN
      key_d       = key_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d     = block;
`ifdef MIXCOL_ARK_EN
               key_d      = round_key;
`endif
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            for (int unsigned c = 0; c < NUM_COLS; c++) begin
               if (cnt_q == CNT_W'(c)) begin
                  work_d[BLOCK_W-1-COL_W*c -: COL_W] = col_new;
               end
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_COL) begin
               cnt_d       = '0;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            // in_ready only returns after the handshake edge, never alongside it.
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            cnt_d       = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         work_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef MIXCOL_ARK_EN
         key_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         work_q      <= work_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef MIXCOL_ARK_EN
         key_q       <= key_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign new_block = work_q;

endmodule

// File: tb/tb_mix_column_seq.sv
// Directed bench for mix_column_seq: FIPS-197 columns, latency, backpressure,
// mid-BUSY reset and back-to-back streaming against a GF(2^8) reference.
module tb_mix_column_seq;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] block;
   logic [127:0] round_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] new_block;

   int n_checks = 0;
   int n_errors = 0;

   mix_column_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .block     (block),
`ifdef MIXCOL_ARK_EN
      .round_key (round_key),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .new_block (new_block)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generic shift-and-add GF(2^8) multiply.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1B) : {aa[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] blk, input logic [127:0] key);
      logic [127:0] r;
      logic [7:0] s0, s1, s2, s3;
      for (int c = 0; c < 4; c++) begin
         {s0, s1, s2, s3} = blk[127-32*c -: 32];
         r[127-32*c -: 32] = {gmul(8'h02, s0) ^ gmul(8'h03, s1) ^ s2 ^ s3,
                              s0 ^ gmul(8'h02, s1) ^ gmul(8'h03, s2) ^ s3,
                              s0 ^ s1 ^ gmul(8'h02, s2) ^ gmul(8'h03, s3),
                              gmul(8'h03, s0) ^ s1 ^ s2 ^ gmul(8'h02, s3)};
      end
      return r ^ key;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Stimulus only: accept blk, scramble inputs, wait for out_valid (bounded).
   task automatic run_block(input logic [127:0] blk, input logic [127:0] key,
                            output logic [127:0] res, output int lat, output bit ir_seen);
      int w = 0;
      while (!in_ready && w < 20) begin tick(); w++; end
      block     = blk;
      round_key = key;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      block     = '1;
      round_key = '1;
      lat = 0;
      ir_seen = 1'b0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
         if (in_ready) ir_seen = 1'b1;
      end
      if (!out_valid) lat = -1;
      res = new_block;
   endtask

   task automatic release_block();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
      n_checks++;
      if (new_block !== 128'h0) begin
         n_errors++;
         $display("FAIL reset_work: got %h want 0", new_block);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_columns();
      logic [31:0] vin [7]  = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6,
                                32'hd4d4d4d5, 32'h2d26314c, 32'h00000000};
      logic [31:0] vout [7] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6,
                                32'hd5d5d7d6, 32'h4d7ebdf8, 32'h00000000};
      logic [127:0] res;
      int lat;
      bit irs;
      for (int i = 0; i < 7; i++) begin
         run_block({vin[i], 96'h0}, 128'h0, res, lat, irs);
         n_checks++;
         if (res !== {vout[i], 96'h0}) begin
            n_errors++;
            $display("FAIL column_%0d: got %h want %h", i, res, {vout[i], 96'h0});
         end
         release_block();
      end
   endtask

   task automatic test_full_block();
      logic [127:0] res;
      int lat;
      bit irs;
      run_block(128'hdb135345f20a225cc6c6c6c6d4d4d4d5, 128'h0, res, lat, irs);
      n_checks++;
      if (res !== 128'h8e4da1bc9fdc589dc6c6c6c6d5d5d7d6) begin
         n_errors++;
         $display("FAIL full_block: got %h want 8e4da1bc9fdc589dc6c6c6c6d5d5d7d6", res);
      end
      n_checks++;
      if (lat != 4) begin
         n_errors++;
         $display("FAIL full_latency: got %0d want 4", lat);
      end
      n_checks++;
      if (irs) begin
         n_errors++;
         $display("FAIL full_in_ready: in_ready seen 1 during BUSY/DONE, want 0");
      end
      release_block();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL full_return: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] blk, res, expv;
      int lat, bad;
      bit irs;
      blk  = rand128();
      expv = model(blk, 128'h0);
      run_block(blk, 128'h0, res, lat, irs);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (new_block !== expv || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0 || res !== expv) begin
         n_errors++;
         $display("FAIL backpressure_hold: %0d unstable cycles, got %h want %h", bad, new_block, expv);
      end
      release_block();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [127:0] res;
      int lat, bad;
      bit irs;
      block    = rand128();
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || new_block !== 128'h0) begin
         n_errors++;
         $display("FAIL midreset: out_valid=%b in_ready=%b work=%h, want 0/1/0",
                  out_valid, in_ready, new_block);
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_errors++;
         $display("FAIL midreset_discard: out_valid high %0d cycles, want 0", bad);
      end
      run_block({32'h2d26314c, 96'h0}, 128'h0, res, lat, irs);
      n_checks++;
      if (res !== {32'h4d7ebdf8, 96'h0} || lat != 4) begin
         n_errors++;
         $display("FAIL midreset_next: got %h lat %0d want %h lat 4", res, lat, {32'h4d7ebdf8, 96'h0});
      end
      release_block();
   endtask

   task automatic test_back_to_back();
      localparam int N = 88;
      logic [127:0] q [$];
      logic [127:0] cur, ck, nb, expv;
      int acc = 0, rcv = 0, cyc = 0, last_acc = -1;
      int gap_bad = 0, lat_bad = 0, overlap = 0;
      bit acc_now, hs_now;
      cur = rand128();
`ifdef MIXCOL_ARK_EN
      ck = rand128();
`else
      ck = 128'h0;
`endif
      block     = cur;
      round_key = ck;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while ((acc < N || rcv < N) && cyc < N * 6 + 50) begin
         acc_now = in_ready && in_valid;
         hs_now  = out_valid;
         nb      = new_block;
         if (in_ready && out_valid) overlap++;
         tick();
         cyc++;
         if (hs_now) begin
            expv = (q.size() > 0) ? q.pop_front() : 128'hx;
            n_checks++;
            if (nb !== expv) begin
               n_errors++;
               $display("FAIL b2b_result_%0d: got %h want %h", rcv, nb, expv);
            end
            // Accept edge to return edge spans 5 cycles.
            if (cyc - last_acc != 5) lat_bad++;
            rcv++;
         end
         if (acc_now) begin
            q.push_back(model(cur, ck));
            // The IDLE cycle after the return edge makes accepts 6 edges apart.
            if (last_acc >= 0 && cyc - last_acc != 6) gap_bad++;
            last_acc = cyc;
            acc++;
            cur   = rand128();
            block = cur;
`ifdef MIXCOL_ARK_EN
            ck        = rand128();
            round_key = ck;
`endif
            if (acc == N) in_valid = 1'b0;
         end
      end
      out_ready = 1'b0;
      n_checks++;
      if (acc != N || rcv != N) begin
         n_errors++;
         $display("FAIL b2b_count: accepted %0d returned %0d, want %0d each", acc, rcv, N);
      end
      n_checks++;
      if (gap_bad != 0 || lat_bad != 0) begin
         n_errors++;
         $display("FAIL b2b_rate: %0d bad accept gaps, %0d bad return latencies, want 0", gap_bad, lat_bad);
      end
      n_checks++;
      if (overlap != 0) begin
         n_errors++;
         $display("FAIL b2b_overlap: in_ready with out_valid %0d cycles, want 0", overlap);
      end
   endtask

`ifdef MIXCOL_ARK_EN
   task automatic test_ark();
      logic [127:0] res;
      int lat;
      bit irs;
      run_block({4{32'h01010101}}, {4{32'hffffffff}}, res, lat, irs);
      n_checks++;
      if (res !== {4{32'hfefefefe}} || lat != 4) begin
         n_errors++;
         $display("FAIL ark: got %h lat %0d want %h lat 4", res, lat, {4{32'hfefefefe}});
      end
      release_block();
   endtask
`endif

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      block     = '0;
      round_key = '0;
      test_reset();
      test_columns();
      test_full_block();
      test_backpressure();
      test_reset_mid_busy();
      test_back_to_back();
`ifdef MIXCOL_ARK_EN
      test_ark();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
